char_sweep_sequencer: RTL and testbench
=======================================

Name: char_sweep_sequencer

Overview:
- Synthesizable sequencer for the cell-characterization bench.
- Steps through a fixed grid of input-slope and load-capacitor settings, slope outer and capacitor inner. At each grid point it waits for the DUT to settle, fires a rising edge on the DUT input and checks the logic output.
- Emits one measurement record per grid point over a valid/ready handshake to the results writer, then releases the input.
- Sits between the run-control logic and the breadboard model (slope/cap index decoders, delay measurer).

Parameters:
NBSLOPES, 7, number of input-slope table entries (≥1)
NBCAPA, 7, number of load-capacitor table entries (≥1)
IDX_W, 3, width of slope/cap index outputs (2^IDX_W ≥ max(NBSLOPES,NBCAPA))
TICK_CYCLES, 10, clock cycles per settle tick (≥1)
MEAS_W, 32, width of the measured propagation-time code

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin sweep; sampled only in IDLE, DONE or ERR
slope_idx  out  IDX_W  current slope table index
capa_idx  out  IDX_W  current capacitor table index
din  out  1  logic input driven to the DUT
dout_sample  in  1  DUT logic output, synchronous to clk
meas_code  in  MEAS_W  measured fall propagation time, stable while din=1
rec_valid  out  1  record available
rec_ready  in  1  writer accepts record
rec_slope  out  IDX_W  record slope index
rec_capa  out  IDX_W  record capacitor index
rec_row_first  out  1  record is first of its slope row (capa_idx=0)
rec_meas  out  MEAS_W  record measurement
busy  out  1  sweep in progress
done  out  1  sweep completed; level, held until next start
error  out  1  functional check failed; level, held until next start

Behaviour:
- Reset, asynchronous: state IDLE, all outputs 0, tick counter 0.
- States: IDLE, SET_SLOPE, SET_CAPA, ARM, SETTLE, CHECK, EMIT, RELEASE, DONE, ERR.
- Wait states (SET_SLOPE, SET_CAPA, ARM, SETTLE, RELEASE) each occupy exactly TICK_CYCLES cycles. Counter loads TICK_CYCLES-1 on entry; the state exits on the edge where the counter is 0.
- IDLE/DONE/ERR + start=1 → SET_SLOPE. On that edge: slope_idx=0, capa_idx=0, done=0, error=0, busy=1.
- SET_SLOPE → SET_CAPA.
- SET_CAPA → ARM.
- ARM → SETTLE; din is set to 1 on this edge.
- SETTLE → CHECK.
- CHECK, 1 cycle:
  - dout_sample==!din, i.e. 0 → EMIT. rec_* fields are registered on this edge; rec_meas=meas_code, rec_row_first=(capa_idx==0).
  - Otherwise → ERR. din=0, busy=0, error=1; indices freeze at the failing point for debug.
- EMIT: rec_valid=1, payload held stable until rec_valid&&rec_ready. On that edge rec_valid=0 → RELEASE. Stalls indefinitely; no timeout.
- RELEASE exit: din=0, then one of:
  - capa_idx<NBCAPA-1: capa_idx++ → SET_CAPA.
  - else if slope_idx<NBSLOPES-1: slope_idx++, capa_idx=0 → SET_SLOPE.
  - else → DONE. busy=0, done=1; indices hold the last point.
- din is 1 exactly during SETTLE, CHECK, EMIT and RELEASE.
- start is ignored while busy=1.
- Index wrap: none. Counters never exceed NBSLOPES-1/NBCAPA-1.
- Cycle count with rec_ready tied 1: each point takes 4·TICK_CYCLES+2 cycles, each row adds TICK_CYCLES. DONE is entered NBSLOPES·(TICK_CYCLES+NBCAPA·(4·TICK_CYCLES+2)) edges after the start edge; defaults give 2128.
- Reset mid-sweep: immediate return to IDLE; din and rec_valid drop asynchronously; no partial record is delivered.

Test Plan:
- Defaults, ideal inverter model (dout=!din), rec_ready=1, one start pulse → 49 records in order (0,0),(0,1)…(6,6). rec_row_first=1 on the 7 records with capa=0. rec_meas equals the meas_code driven per point. done=1 at exactly 2128 edges after start; error=0.
- Same sweep with rec_ready low for 5 cycles on every record → payload stable while stalled, no record lost or duplicated, din stays 1 during the stall; total time grows by 49·5 cycles.
- Faulty DUT model forcing dout=1 at point (2,3) → error=1 and busy=0 entering ERR from CHECK of (2,3). slope_idx=2, capa_idx=3, din=0. Exactly 17 records delivered. A new start clears error and restarts at (0,0).
- start pulsed again at point (1,1) while busy → ignored; record sequence is identical to the first scenario.
- rst asserted asynchronously during EMIT of (4,2) → same-instant din=0, rec_valid=0, busy=0, state IDLE; next start restarts at (0,0).
- NBSLOPES=1, NBCAPA=1, TICK_CYCLES=1 → one record; done at edge 1·(1+1·6)=7 after start.

Source files
------------

// File: rtl/char_sweep_sequencer.sv
// char_sweep_sequencer
// Walks the characterization grid (slope outer, load capacitor inner). At each
// point it lets the breadboard settle, raises din, checks the inverted logic
// output, emits one measurement record over valid/ready, then releases din.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             begin a sweep (honoured only when not busy)
//   slope_idx/capa_idx current grid point driven to the table decoders
//   din               logic input to the device under characterization
//   dout_sample       device logic output, synchronous to clk
//   meas_code         measured fall propagation time, valid while din=1
//   rec_*             measurement record, valid/ready handshake
//   busy/done/error   sweep status; done/error are levels held until next start
module char_sweep_sequencer #(
    parameter int unsigned NBSLOPES    = 7,
    parameter int unsigned NBCAPA      = 7,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned TICK_CYCLES = 10,
    parameter int unsigned MEAS_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [IDX_W-1:0]  slope_idx,
    output logic [IDX_W-1:0]  capa_idx,
    output logic              din,
    input  logic              dout_sample,
    input  logic [MEAS_W-1:0] meas_code,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [IDX_W-1:0]  rec_slope,
    output logic [IDX_W-1:0]  rec_capa,
    output logic              rec_row_first,
    output logic [MEAS_W-1:0] rec_meas,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TickLoad  = CNT_W'(TICK_CYCLES - 1);
    localparam logic [IDX_W-1:0] SlopeLast = IDX_W'(NBSLOPES - 1);
    localparam logic [IDX_W-1:0] CapaLast  = IDX_W'(NBCAPA - 1);

    localparam logic [3:0] StIdle     = 4'd0;
    localparam logic [3:0] StSetSlope = 4'd1;
    localparam logic [3:0] StSetCapa  = 4'd2;
    localparam logic [3:0] StArm      = 4'd3;
    localparam logic [3:0] StSettle   = 4'd4;
    localparam logic [3:0] StCheck    = 4'd5;
    localparam logic [3:0] StEmit     = 4'd6;
    localparam logic [3:0] StRelease  = 4'd7;
    localparam logic [3:0] StDone     = 4'd8;
    localparam logic [3:0] StErr      = 4'd9;

    logic [3:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  slope_q, slope_d;
    logic [IDX_W-1:0]  capa_q, capa_d;
    logic              din_q, din_d;
    logic              rec_valid_q, rec_valid_d;
    logic [IDX_W-1:0]  rec_slope_q, rec_slope_d;
    logic [IDX_W-1:0]  rec_capa_q, rec_capa_d;
    logic              rec_row_first_q, rec_row_first_d;
    logic [MEAS_W-1:0] rec_meas_q, rec_meas_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              tick_end;

    assign tick_end = (cnt_q == '0);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        slope_d         = slope_q;
        capa_d          = capa_q;
        din_d           = din_q;
        rec_valid_d     = rec_valid_q;
        rec_slope_d     = rec_slope_q;
        rec_capa_d      = rec_capa_q;
        rec_row_first_d = rec_row_first_q;
        rec_meas_d      = rec_meas_q;
        busy_d          = busy_q;
        done_d          = done_q;
        error_d         = error_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StSetSlope;
                    cnt_d   = TickLoad;
                    slope_d = '0;
                    capa_d  = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StSetSlope, StSetCapa, StArm, StSettle: begin
                if (!tick_end) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d = TickLoad;
                    unique case (state_q)
                        StSetSlope: state_d = StSetCapa;
                        StSetCapa:  state_d = StArm;
                        StArm: begin
                            state_d = StSettle;
                            din_d   = 1'b1;
                        end
                        default:    state_d = StCheck;
                    endcase
                end
            end
            StCheck: begin
                // A healthy inverting cell answers with the complement of din.
                if (dout_sample == !din_q) begin
                    state_d         = StEmit;
                    rec_valid_d     = 1'b1;
                    rec_slope_d     = slope_q;
                    rec_capa_d      = capa_q;
                    rec_row_first_d = (capa_q == '0);
                    rec_meas_d      = meas_code;
                end else begin
                    // Indices stay at the failing point for debug.
                    state_d = StErr;
                    din_d   = 1'b0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end
            end
            StEmit: begin
                if (rec_ready) begin
                    state_d     = StRelease;
                    rec_valid_d = 1'b0;
                    cnt_d       = TickLoad;
                end
            end
            StRelease: begin
                if (!tick_end) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    din_d = 1'b0;
                    cnt_d = TickLoad;
                    if (capa_q < CapaLast) begin
                        capa_d  = capa_q + IDX_W'(1);
                        state_d = StSetCapa;
                    end else if (slope_q < SlopeLast) begin
                        slope_d = slope_q + IDX_W'(1);
                        capa_d  = '0;
                        state_d = StSetSlope;
                    end else begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            slope_q         <= '0;
            capa_q          <= '0;
            din_q           <= 1'b0;
            rec_valid_q     <= 1'b0;
            rec_slope_q     <= '0;
            rec_capa_q      <= '0;
            rec_row_first_q <= 1'b0;
            rec_meas_q      <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            slope_q         <= slope_d;
            capa_q          <= capa_d;
            din_q           <= din_d;
            rec_valid_q     <= rec_valid_d;
            rec_slope_q     <= rec_slope_d;
            rec_capa_q      <= rec_capa_d;
            rec_row_first_q <= rec_row_first_d;
            rec_meas_q      <= rec_meas_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
        end
    end

    assign slope_idx     = slope_q;
    assign capa_idx      = capa_q;
    assign din           = din_q;
    assign rec_valid     = rec_valid_q;
    assign rec_slope     = rec_slope_q;
    assign rec_capa      = rec_capa_q;
    assign rec_row_first = rec_row_first_q;
    assign rec_meas      = rec_meas_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_char_sweep_sequencer.sv
// Scoreboard bench for char_sweep_sequencer: default 7x7 grid instance plus a
// 1x1, one-cycle-tick instance for the minimal configuration.
module tb_char_sweep_sequencer;

    localparam int NS = 7;
    localparam int NC = 7;
    localparam int SWEEP_EDGES = 2128;

    typedef struct packed {
        logic [2:0]  s;
        logic [2:0]  c;
        logic        rf;
        logic [31:0] m;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  slope_idx, capa_idx, rec_slope, rec_capa;
    logic        din, dout_sample, rec_valid, rec_ready, rec_row_first;
    logic [31:0] meas_code, rec_meas;
    logic        busy, done, error;

    logic        s_start;
    logic [2:0]  s_slope_idx, s_capa_idx, s_rec_slope, s_rec_capa;
    logic        s_din, s_rec_valid, s_rec_row_first, s_busy, s_done, s_error;
    logic [31:0] s_rec_meas;

    rec_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          rec_count = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic [31:0] salt = 32'h0;
    logic        fault_en = 1'b0;
    logic        stall_mode = 1'b0;
    logic        block_42 = 1'b0;
    int          stall_cnt = 0;

    // Breadboard model: ideal inverter (optionally stuck high at (2,3)) and a
    // per-point measurement code.
    assign dout_sample = (fault_en && slope_idx == 3'd2 && capa_idx == 3'd3) ? 1'b1 : !din;
    assign meas_code   = salt ^ {16'hA5A5, 5'b0, slope_idx, 5'b0, capa_idx};

    char_sweep_sequencer u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .slope_idx     (slope_idx),
        .capa_idx      (capa_idx),
        .din           (din),
        .dout_sample   (dout_sample),
        .meas_code     (meas_code),
        .rec_valid     (rec_valid),
        .rec_ready     (rec_ready),
        .rec_slope     (rec_slope),
        .rec_capa      (rec_capa),
        .rec_row_first (rec_row_first),
        .rec_meas      (rec_meas),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    char_sweep_sequencer #(
        .NBSLOPES    (1),
        .NBCAPA      (1),
        .IDX_W       (3),
        .TICK_CYCLES (1),
        .MEAS_W      (32)
    ) u_small (
        .clk           (clk),
        .rst           (rst),
        .start         (s_start),
        .slope_idx     (s_slope_idx),
        .capa_idx      (s_capa_idx),
        .din           (s_din),
        .dout_sample   (!s_din),
        .meas_code     (32'hCAFE0001),
        .rec_valid     (s_rec_valid),
        .rec_ready     (1'b1),
        .rec_slope     (s_rec_slope),
        .rec_capa      (s_rec_capa),
        .rec_row_first (s_rec_row_first),
        .rec_meas      (s_rec_meas),
        .busy          (s_busy),
        .done          (s_done),
        .error         (s_error)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_points(input int n);
        int k;
        k = 0;
        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < NC; c++) begin
                if (k < n) begin
                    exp_q.push_back('{s: 3'(s), c: 3'(c), rf: (c == 0),
                                      m: salt ^ {16'hA5A5, 5'b0, 3'(s), 5'b0, 3'(c)}});
                end
                k++;
            end
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string name, input int exp_edges);
        int n;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=notdone required=done", name);
        end else begin
            check(name, 64'(cyc - start_cyc), 64'(exp_edges));
            check({name, "_error"}, 64'(error), 64'd0);
            check({name, "_busy"}, 64'(busy), 64'd0);
            check({name, "_last_point"}, 64'({slope_idx, capa_idx}), 64'({3'd6, 3'd6}));
        end
    endtask

    // Ready driver: updated 1 time unit after each rising edge.
    initial begin
        rec_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode && rec_valid) begin
                if (stall_cnt < 5) begin
                    rec_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    rec_ready = 1'b1;
                end
            end else if (block_42 && rec_valid && slope_idx == 3'd4 && capa_idx == 3'd2) begin
                rec_ready = 1'b0;
            end else begin
                stall_cnt = 0;
                rec_ready = 1'b1;
            end
        end
    end

    // Monitor: every cycle a record is presented its payload must match the
    // queue head (so stalls also prove stability); pop on handshake.
    initial forever begin
        @(negedge clk);
        if (!rst && rec_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_record actual=(%0d,%0d) required=none",
                         rec_slope, rec_capa);
            end else begin
                check("rec_payload", 64'({rec_slope, rec_capa, rec_row_first, rec_meas}),
                      64'(exp_q[0]));
                check("din_during_emit", 64'(din), 64'd1);
                if (rec_ready) begin
                    void'(exp_q.pop_front());
                    rec_count++;
                end
            end
        end
    end

    initial begin
        int rec0;
        int n;
        logic got;
        rst = 1'b1;
        start = 1'b0;
        s_start = 1'b0;
        #1;
        check("reset_rec_valid", 64'(rec_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        check("reset_din", 64'(din), 64'd0);
        check("reset_idx", 64'({slope_idx, capa_idx}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: plain sweep, ready always high.
        salt = 32'h1234_0000;
        rec0 = rec_count;
        push_points(49);
        do_start();
        check("start_busy", 64'(busy), 64'd1);
        check("start_idx", 64'({slope_idx, capa_idx}), 64'd0);
        wait_done("sweep_done_edges", SWEEP_EDGES);
        check("sweep_records", 64'(rec_count - rec0), 64'd49);
        check("sweep_queue_empty", 64'(exp_q.size()), 64'd0);

        // 2: five-cycle stall on every record.
        stall_mode = 1'b1;
        salt = 32'h0BAD_F00D;
        rec0 = rec_count;
        push_points(49);
        do_start();
        wait_done("stall_done_edges", SWEEP_EDGES + 49 * 5);
        check("stall_records", 64'(rec_count - rec0), 64'd49);
        check("stall_queue_empty", 64'(exp_q.size()), 64'd0);
        stall_mode = 1'b0;

        // 3: device fails at (2,3).
        fault_en = 1'b1;
        salt = 32'h7777_0000;
        rec0 = rec_count;
        push_points(17);
        do_start();
        n = 0;
        while (!error && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("fault_error", 64'(error), 64'd1);
        check("fault_busy", 64'(busy), 64'd0);
        check("fault_done", 64'(done), 64'd0);
        check("fault_din", 64'(din), 64'd0);
        check("fault_idx", 64'({slope_idx, capa_idx}), 64'({3'd2, 3'd3}));
        repeat (3) @(negedge clk);
        check("fault_records", 64'(rec_count - rec0), 64'd17);
        check("fault_queue_empty", 64'(exp_q.size()), 64'd0);

        // 4: restart clears error; a start pulse at (1,1) must be ignored.
        fault_en = 1'b0;
        salt = 32'h5555_AAAA;
        rec0 = rec_count;
        push_points(49);
        do_start();
        check("restart_error", 64'(error), 64'd0);
        check("restart_idx", 64'({slope_idx, capa_idx}), 64'd0);
        n = 0;
        while (!(slope_idx == 3'd1 && capa_idx == 3'd1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reached_1_1", 64'({slope_idx, capa_idx}), 64'({3'd1, 3'd1}));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_ignored", 64'({busy, slope_idx, capa_idx}), 64'({1'b1, 3'd1, 3'd1}));
        wait_done("restart_done_edges", SWEEP_EDGES);
        check("restart_records", 64'(rec_count - rec0), 64'd49);
        check("restart_queue_empty", 64'(exp_q.size()), 64'd0);

        // 5: asynchronous reset while (4,2) is being emitted.
        block_42 = 1'b1;
        salt = 32'h0F0F_3C3C;
        rec0 = rec_count;
        push_points(49);
        do_start();
        n = 0;
        while (!(rec_valid && slope_idx == 3'd4 && capa_idx == 3'd2) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("emit_4_2_reached", 64'(rec_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_din", 64'(din), 64'd0);
        check("arst_rec_valid", 64'(rec_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_idx", 64'({slope_idx, capa_idx}), 64'd0);
        check("arst_records", 64'(rec_count - rec0), 64'd30);
        @(negedge clk);
        rst = 1'b0;
        block_42 = 1'b0;
        exp_q.delete();
        salt = 32'h2468_1357;
        rec0 = rec_count;
        push_points(49);
        do_start();
        check("arst_restart_idx", 64'({busy, slope_idx, capa_idx}), 64'({1'b1, 6'd0}));
        wait_done("arst_restart_done_edges", SWEEP_EDGES);
        check("arst_restart_records", 64'(rec_count - rec0), 64'd49);

        // 6: minimal 1x1 grid, one-cycle ticks.
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        start_cyc = cyc;
        got = 1'b0;
        n = 0;
        while (!s_done && n < 100) begin
            @(negedge clk);
            if (s_rec_valid) begin
                got = 1'b1;
                check("small_record",
                      64'({s_rec_slope, s_rec_capa, s_rec_row_first, s_rec_meas}),
                      64'({3'd0, 3'd0, 1'b1, 32'hCAFE0001}));
            end
            n++;
        end
        check("small_got_record", 64'(got), 64'd1);
        check("small_done_edges", 64'(cyc - start_cyc), 64'd7);
        check("small_status", 64'({s_done, s_busy, s_error}), 64'({1'b1, 1'b0, 1'b0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
